// File: rtl/eeprom_arb_pkg.sv
// -----------------------------------------------------------------------------
// eeprom_arb_pkg
//
// Shared definitions for the EEPROM word-store arbiter.
//   - arb_state_e : sequencer states (IDLE, EMU, HOST)
//   - ADDR_W_DEF / DATA_W_DEF : default word address / data widths
//   - EMU_RD_LAT  : worst-case cycles from emu_re_i to new emu_data_o.
//                   The emulator integration relies on this number and must
//                   not sample emu_data_o earlier than EMU_RD_LAT+1 cycles
//                   after issuing a read.
// -----------------------------------------------------------------------------
package eeprom_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam int EMU_RD_LAT = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMU  = 2'd1,
    HOST = 2'd2
  } arb_state_e;

  // True for the states that drive a RAM access this cycle.
  function automatic logic is_access_state(input arb_state_e st);
    return (st == EMU) || (st == HOST);
  endfunction

endpackage : eeprom_arb_pkg

// File: rtl/eeprom_word_arb.sv
// -----------------------------------------------------------------------------
// eeprom_word_arb
//
// Arbiter/sequencer sharing one synchronous single-port RAM (1-cycle read
// latency) between the Microwire EEPROM emulator read port and a host
// register-bus port. The emulator always wins arbitration; every access is
// followed by a one-cycle IDLE bubble, which bounds emulator latency to
// EMU_RD_LAT cycles and guarantees a held host request is granted only once.
//
// Optional feature macro: EEPROM_ARB_WP_EN
//   When defined, adds wp_i (write protect) and host_err_o. A protected host
//   write is still granted but does not touch the RAM; host_err_o pulses with
//   the grant.
//
// Ports
//   clk_i          : clock, all logic on posedge
//   rst_ni         : synchronous active-low reset
//   emu_addr_i     : emulator read address, sampled with emu_re_i
//   emu_re_i       : emulator read pulse
//   emu_data_o     : last emulator read word, held until the next one lands
//   host_req_i     : host request, held with stable fields until host_gnt_o
//   host_we_i      : host write (1) / read (0)
//   host_addr_i    : host word address
//   host_wdata_i   : host write data
//   host_gnt_o     : one-cycle grant, request consumed
//   host_rvalid_o  : one-cycle host read-data strobe
//   host_rdata_o   : host read data, held after the strobe
//   ram_en_o       : RAM enable
//   ram_we_o       : RAM write enable
//   ram_addr_o     : RAM word address
//   ram_wdata_o    : RAM write data
//   ram_rdata_i    : RAM read data, valid the cycle after a read enable
//   wp_i           : (EEPROM_ARB_WP_EN) host write protect
//   host_err_o     : (EEPROM_ARB_WP_EN) protected-write error pulse
// -----------------------------------------------------------------------------
module eeprom_word_arb
  import eeprom_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,

  input  logic [ADDR_W-1:0] emu_addr_i,
  input  logic              emu_re_i,
  output logic [DATA_W-1:0] emu_data_o,

  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic              host_gnt_o,
  output logic              host_rvalid_o,
  output logic [DATA_W-1:0] host_rdata_o,

  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
`ifdef EEPROM_ARB_WP_EN
  ,
  input  logic              wp_i,
  output logic              host_err_o
`endif
);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  arb_state_e        state_reg, state_next;

  logic              emu_pend_reg, emu_pend_next;
  logic [ADDR_W-1:0] emu_addr_reg;      // latest requested emulator address
  logic [ADDR_W-1:0] emu_acc_addr_reg;  // address frozen for the EMU access
  logic              enter_emu;

  // Capture flags: set in the cycle after the RAM read was issued, i.e. the
  // cycle in which ram_rdata_i carries the word.
  logic              emu_cap_reg;
  logic              host_cap_reg;

  logic [DATA_W-1:0] emu_data_reg;
  logic [DATA_W-1:0] host_rdata_reg;
  logic              host_rvalid_reg;

  // Write-protect gating of the host access.
  logic              host_wr_blocked;

`ifdef EEPROM_ARB_WP_EN
  assign host_wr_blocked = host_we_i & wp_i;
`else
  assign host_wr_blocked = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = IDLE;
    case (state_reg)
      IDLE: begin
        if (emu_pend_reg) begin
          state_next = EMU;
        end else if (host_req_i) begin
          state_next = HOST;
        end else begin
          state_next = IDLE;
        end
      end
      // Both access states last one cycle; the return to IDLE is the bubble
      // that keeps a still-asserted host request from being granted twice.
      EMU:     state_next = IDLE;
      HOST:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign enter_emu = (state_reg == IDLE) && (state_next == EMU);

  // A new emulator pulse always (re)arms the pending flag, even in the cycle
  // the previous one is being taken; the access address is frozen separately
  // so the overwrite cannot corrupt the access already scheduled.
  always_comb begin
    emu_pend_next = emu_pend_reg;
    if (emu_re_i) begin
      emu_pend_next = 1'b1;
    end else if (enter_emu) begin
      emu_pend_next = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // RAM / grant outputs, decoded from the state register
  // ---------------------------------------------------------------------------
  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    host_gnt_o  = 1'b0;
    case (state_reg)
      EMU: begin
        ram_en_o   = 1'b1;
        ram_addr_o = emu_acc_addr_reg;
      end
      HOST: begin
        host_gnt_o = 1'b1;
        // A protected write is consumed without touching the RAM bus at all.
        if (!host_wr_blocked) begin
          ram_en_o    = 1'b1;
          ram_we_o    = host_we_i;
          ram_addr_o  = host_addr_i;
          ram_wdata_o = host_wdata_i;
        end
      end
      default: begin
        ram_en_o = 1'b0;
      end
    endcase
  end

`ifdef EEPROM_ARB_WP_EN
  assign host_err_o = (state_reg == HOST) && host_wr_blocked;
`endif

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg        <= IDLE;
      emu_pend_reg     <= 1'b0;
      emu_addr_reg     <= '0;
      emu_acc_addr_reg <= '0;
      emu_cap_reg      <= 1'b0;
      host_cap_reg     <= 1'b0;
      emu_data_reg     <= '0;
      host_rdata_reg   <= '0;
      host_rvalid_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      emu_pend_reg <= emu_pend_next;

      if (emu_re_i) begin
        emu_addr_reg <= emu_addr_i;
      end
      if (enter_emu) begin
        emu_acc_addr_reg <= emu_addr_reg;
      end

      emu_cap_reg  <= (state_reg == EMU);
      host_cap_reg <= (state_reg == HOST) && !host_we_i;

      if (emu_cap_reg) begin
        emu_data_reg <= ram_rdata_i;
      end
      if (host_cap_reg) begin
        host_rdata_reg <= ram_rdata_i;
      end
      // Strobe lines up with the registered data, two cycles after the grant.
      host_rvalid_reg <= host_cap_reg;
    end
  end

  assign emu_data_o    = emu_data_reg;
  assign host_rdata_o  = host_rdata_reg;
  assign host_rvalid_o = host_rvalid_reg;

  // Sanity: a grant only ever coincides with an access state.
  logic unused_access_state;
  assign unused_access_state = is_access_state(state_reg);

endmodule : eeprom_word_arb

// File: tb/tb_eeprom_word_arb.sv
// -----------------------------------------------------------------------------
// tb_eeprom_word_arb
//
// Directed bench for eeprom_word_arb. Stimulus pushes expected RAM accesses,
// grants, read strobes and output probes (with absolute cycle numbers) into
// queues; a monitor process on the falling edge compares whatever the DUT
// presents against them. A behavioural RAM closes the loop.
// Builds with or without EEPROM_ARB_WP_EN.
// -----------------------------------------------------------------------------
module tb_eeprom_word_arb;

  logic        clk;
  logic        rst_ni;
  logic [7:0]  emu_addr_i;
  logic        emu_re_i;
  logic [15:0] emu_data_o;
  logic        host_req_i;
  logic        host_we_i;
  logic [7:0]  host_addr_i;
  logic [15:0] host_wdata_i;
  logic        host_gnt_o;
  logic        host_rvalid_o;
  logic [15:0] host_rdata_o;
  logic        ram_en_o;
  logic        ram_we_o;
  logic [7:0]  ram_addr_o;
  logic [15:0] ram_wdata_o;
  logic [15:0] ram_rdata_i;
`ifdef EEPROM_ARB_WP_EN
  logic        wp_i;
  logic        host_err_o;
`endif

  eeprom_word_arb #(.ADDR_W(8), .DATA_W(16)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .emu_addr_i   (emu_addr_i),
    .emu_re_i     (emu_re_i),
    .emu_data_o   (emu_data_o),
    .host_req_i   (host_req_i),
    .host_we_i    (host_we_i),
    .host_addr_i  (host_addr_i),
    .host_wdata_i (host_wdata_i),
    .host_gnt_o   (host_gnt_o),
    .host_rvalid_o(host_rvalid_o),
    .host_rdata_o (host_rdata_o),
    .ram_en_o     (ram_en_o),
    .ram_we_o     (ram_we_o),
    .ram_addr_o   (ram_addr_o),
    .ram_wdata_o  (ram_wdata_o),
    .ram_rdata_i  (ram_rdata_i)
`ifdef EEPROM_ARB_WP_EN
    ,
    .wp_i         (wp_i),
    .host_err_o   (host_err_o)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter: value n during the cycle that starts at the n-th posedge.
  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural single-port RAM, 1-cycle read latency.
  logic [15:0] mem [256];
  always @(posedge clk) begin
    if (ram_en_o) begin
      if (ram_we_o) mem[ram_addr_o] <= ram_wdata_o;
      else          ram_rdata_i     <= mem[ram_addr_o];
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct {
    int          cyc;
    logic        we;
    logic [7:0]  a;
    logic [15:0] d;
  } ev_t;

  typedef struct {
    int          cyc;
    int          sel;   // 0: emu_data_o, 1: host_rdata_o
    logic [15:0] v;
  } probe_t;

  ev_t    q_ram[$];
  ev_t    q_gnt[$];
  ev_t    q_rv[$];
  ev_t    q_err[$];
  probe_t q_probe[$];

  int   checks;
  int   errors;
  logic end_req;

  function automatic ev_t mk(input int c, input logic we, input logic [7:0] a,
                             input logic [15:0] d);
    ev_t e;
    e.cyc = c; e.we = we; e.a = a; e.d = d;
    return e;
  endfunction

  task automatic exp_ram(input int c, input logic we, input logic [7:0] a,
                         input logic [15:0] d);
    q_ram.push_back(mk(c, we, a, d));
  endtask

  task automatic exp_gnt(input int c);
    q_gnt.push_back(mk(c, 1'b0, 8'h00, 16'h0000));
  endtask

  task automatic exp_rv(input int c, input logic [15:0] d);
    q_rv.push_back(mk(c, 1'b0, 8'h00, d));
  endtask

  task automatic exp_err(input int c);
    q_err.push_back(mk(c, 1'b0, 8'h00, 16'h0000));
  endtask

  task automatic probe(input int c, input int sel, input logic [15:0] v);
    probe_t p;
    p.cyc = c; p.sel = sel; p.v = v;
    q_probe.push_back(p);
  endtask

  task automatic check_eq(input string name, input logic [31:0] act,
                          input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end else begin
      $display("ok   %s cyc=%0d value=%h", name, cyc, act);
    end
  endtask

  task automatic report_fail(input string name, input int want_cyc);
    checks++;
    errors++;
    $display("FAIL %s cyc=%0d got=event_state_mismatch want_cyc=%0d", name, cyc, want_cyc);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin
    ev_t e;
    int  n;
    forever begin
      @(negedge clk);
      n = cyc;
      if (n >= 1) begin
        // RAM bus must be fully quiet whenever it is not enabled.
        if (!ram_en_o) begin
          checks++;
          if ({ram_we_o, ram_addr_o, ram_wdata_o} !== 25'd0) begin
            errors++;
            $display("FAIL ram_idle cyc=%0d got=%h want=0", n,
                     {ram_we_o, ram_addr_o, ram_wdata_o});
          end
        end

        while (q_ram.size() > 0 && q_ram[0].cyc < n) begin
          report_fail("ram_missing", q_ram[0].cyc);
          void'(q_ram.pop_front());
        end
        if (ram_en_o) begin
          if (q_ram.size() > 0 && q_ram[0].cyc == n) begin
            e = q_ram.pop_front();
            check_eq("ram_access", {7'd0, ram_we_o, ram_addr_o, ram_wdata_o},
                     {7'd0, e.we, e.a, e.d});
          end else begin
            report_fail("ram_unexpected", -1);
          end
        end

        while (q_gnt.size() > 0 && q_gnt[0].cyc < n) begin
          report_fail("gnt_missing", q_gnt[0].cyc);
          void'(q_gnt.pop_front());
        end
        if (host_gnt_o) begin
          if (q_gnt.size() > 0 && q_gnt[0].cyc == n) begin
            void'(q_gnt.pop_front());
            check_eq("host_gnt", {31'd0, host_gnt_o}, 32'd1);
          end else begin
            report_fail("gnt_unexpected", -1);
          end
        end

        while (q_rv.size() > 0 && q_rv[0].cyc < n) begin
          report_fail("rvalid_missing", q_rv[0].cyc);
          void'(q_rv.pop_front());
        end
        if (host_rvalid_o) begin
          if (q_rv.size() > 0 && q_rv[0].cyc == n) begin
            e = q_rv.pop_front();
            check_eq("host_rdata", {16'd0, host_rdata_o}, {16'd0, e.d});
          end else begin
            report_fail("rvalid_unexpected", -1);
          end
        end

`ifdef EEPROM_ARB_WP_EN
        while (q_err.size() > 0 && q_err[0].cyc < n) begin
          report_fail("err_missing", q_err[0].cyc);
          void'(q_err.pop_front());
        end
        if (host_err_o) begin
          if (q_err.size() > 0 && q_err[0].cyc == n) begin
            void'(q_err.pop_front());
            check_eq("host_err", {31'd0, host_gnt_o}, 32'd1);
          end else begin
            report_fail("err_unexpected", -1);
          end
        end
`endif

        for (int i = 0; i < q_probe.size(); ) begin
          if (q_probe[i].cyc == n) begin
            if (q_probe[i].sel == 0)
              check_eq("emu_data", {16'd0, emu_data_o}, {16'd0, q_probe[i].v});
            else
              check_eq("host_rdata_hold", {16'd0, host_rdata_o}, {16'd0, q_probe[i].v});
            q_probe.delete(i);
          end else if (q_probe[i].cyc < n) begin
            report_fail("probe_missed", q_probe[i].cyc);
            q_probe.delete(i);
          end else begin
            i++;
          end
        end

        if (end_req) begin
          check_eq("leftover_expectations",
                   q_ram.size() + q_gnt.size() + q_rv.size() + q_err.size() + q_probe.size(),
                   32'd0);
          $display("Result: errors=%0d of %0d checks", errors, checks);
          $finish;
        end
      end
    end
  end

  // Watchdog: the directed schedule is a few dozen cycles long.
  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic goto_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    cyc         <= 0;
    ram_rdata_i <= 16'h0000;
    for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
    mem[8'h21] <= 16'h5A21;
    mem[8'h34] <= 16'h3434;
    mem[8'h40] <= 16'h4040;
    mem[8'h55] <= 16'h5555;

    checks  = 0;
    errors  = 0;
    end_req = 1'b0;

    // Reset held with both requesters active: nothing may be granted.
    rst_ni       = 1'b0;
    host_req_i   = 1'b1;
    host_we_i    = 1'b0;
    host_addr_i  = 8'h55;
    host_wdata_i = 16'h0000;
    emu_re_i     = 1'b1;
    emu_addr_i   = 8'h77;
`ifdef EEPROM_ARB_WP_EN
    wp_i         = 1'b0;
`endif

    goto_cyc(1);
    for (int c = 1; c <= 3; c++) begin
      probe(c, 0, 16'h0000);
      probe(c, 1, 16'h0000);
    end

    // Release: emulator read is the first access after reset.
    goto_cyc(4);
    rst_ni     = 1'b1;
    host_req_i = 1'b0;
    emu_re_i   = 1'b1;
    emu_addr_i = 8'h21;
    exp_ram(6, 1'b0, 8'h21, 16'h0000);
    probe(7, 0, 16'h0000);
    probe(8, 0, 16'h5A21);

    // Host write 0x12 <- 0xBEEF, waits behind the emulator access.
    goto_cyc(5);
    emu_re_i     = 1'b0;
    host_req_i   = 1'b1;
    host_we_i    = 1'b1;
    host_addr_i  = 8'h12;
    host_wdata_i = 16'hBEEF;
    exp_gnt(8);
    exp_ram(8, 1'b1, 8'h12, 16'hBEEF);

    // Back-to-back host read of 0x12: granted 2 cycles after the write.
    goto_cyc(9);
    host_we_i    = 1'b0;
    host_wdata_i = 16'h0000;
    exp_gnt(10);
    exp_ram(10, 1'b0, 8'h12, 16'h0000);
    exp_rv(12, 16'hBEEF);
    probe(11, 1, 16'h0000);
    probe(12, 1, 16'hBEEF);

    goto_cyc(11);
    host_req_i = 1'b0;

    // Emulator read of 0x12 from IDLE: access t+2, data t+4.
    goto_cyc(12);
    emu_re_i   = 1'b1;
    emu_addr_i = 8'h12;
    exp_ram(14, 1'b0, 8'h12, 16'h0000);
    probe(13, 0, 16'h5A21);
    probe(15, 0, 16'h5A21);
    probe(16, 0, 16'hBEEF);

    goto_cyc(13);
    emu_re_i = 1'b0;

    // Simultaneous emulator read and host read while busy: emulator first.
    goto_cyc(14);
    emu_re_i    = 1'b1;
    emu_addr_i  = 8'h40;
    host_req_i  = 1'b1;
    host_we_i   = 1'b0;
    host_addr_i = 8'h34;
    exp_ram(16, 1'b0, 8'h40, 16'h0000);
    exp_gnt(18);
    exp_ram(18, 1'b0, 8'h34, 16'h0000);
    exp_rv(20, 16'h3434);
    probe(17, 0, 16'hBEEF);
    probe(18, 0, 16'h4040);
    probe(19, 1, 16'hBEEF);
    probe(20, 1, 16'h3434);

    goto_cyc(15);
    emu_re_i = 1'b0;

    // Host decided in IDLE the same cycle emu_re_i arrives: worst case path.
    goto_cyc(19);
    host_addr_i = 8'h55;
    emu_re_i    = 1'b1;
    emu_addr_i  = 8'h21;
    exp_gnt(20);
    exp_ram(20, 1'b0, 8'h55, 16'h0000);
    exp_ram(22, 1'b0, 8'h21, 16'h0000);
    exp_rv(22, 16'h5555);
    probe(21, 1, 16'h3434);
    probe(22, 1, 16'h5555);
    probe(23, 0, 16'h4040);
    probe(24, 0, 16'h5A21);

    goto_cyc(20);
    emu_re_i = 1'b0;

    goto_cyc(21);
    host_req_i = 1'b0;

    // Host write 0x12 <- 0x0000 (write-protected when the feature is built).
    goto_cyc(25);
    host_req_i   = 1'b1;
    host_we_i    = 1'b1;
    host_addr_i  = 8'h12;
    host_wdata_i = 16'h0000;
    exp_gnt(26);
`ifdef EEPROM_ARB_WP_EN
    wp_i = 1'b1;
    exp_err(26);
`else
    exp_ram(26, 1'b1, 8'h12, 16'h0000);
`endif

    // Emulator read-back of 0x12 shows whether the write landed.
    goto_cyc(27);
    host_req_i = 1'b0;
    host_we_i  = 1'b0;
`ifdef EEPROM_ARB_WP_EN
    wp_i       = 1'b0;
`endif
    emu_re_i   = 1'b1;
    emu_addr_i = 8'h12;
    exp_ram(29, 1'b0, 8'h12, 16'h0000);
    probe(30, 0, 16'h5A21);
`ifdef EEPROM_ARB_WP_EN
    probe(31, 0, 16'hBEEF);
`else
    probe(31, 0, 16'h0000);
`endif
    probe(31, 1, 16'h5555);

    goto_cyc(28);
    emu_re_i = 1'b0;

    goto_cyc(40);
    end_req = 1'b1;
  end

endmodule : tb_eeprom_word_arb

// File: doc/eeprom_word_arb.md
# eeprom_word_arb

Arbiter and sequencer for the single-port word store behind the Microwire EEPROM emulator. It shares one synchronous 1-read-latency RAM between the emulator's read port and a host register-bus port that reads and writes words. The emulator always has priority and receives data within a fixed worst-case latency. The block sits between the emulator, the host bridge and the RAM macro.

## Interface
- ADDR_W, 8, word address width
- DATA_W, 16, word width
- clk_i  in  1  single clock, all logic posedge
- rst_ni  in  1  reset, synchronous, active-low
- emu_addr_i  in  ADDR_W  emulator read address, sampled with emu_re_i
- emu_re_i  in  1  emulator read pulse, one cycle
- emu_data_o  out  DATA_W  last word read for emulator, held until next emulator read completes
- host_req_i  in  1  host request; held with fields stable until host_gnt_o
- host_we_i  in  1  1 = write, 0 = read
- host_addr_i  in  ADDR_W  host address
- host_wdata_i  in  DATA_W  host write data
- host_gnt_o  out  1  one-cycle grant; request consumed
- host_rvalid_o  out  1  one-cycle read-data strobe
- host_rdata_o  out  DATA_W  host read data, valid with host_rvalid_o, held after
- ram_en_o, ram_we_o  out  1  RAM enable / write enable
- ram_addr_o  out  ADDR_W  RAM address
- ram_wdata_o  out  DATA_W  RAM write data
- ram_rdata_i  in  DATA_W  RAM read data, valid the cycle after ram_en_o with ram_we_o=0

## Operation
- States: IDLE, EMU, HOST. Every cycle spent in EMU or HOST issues exactly one RAM access, and the FSM then returns to IDLE. Each access is followed by a one-cycle bubble, so a held request is never granted twice.
- IDLE -> EMU if emu_pend. Otherwise IDLE -> HOST if host_req_i. Otherwise stay in IDLE.
- emu_pend/emu_addr_q are set on emu_re_i and cleared on entry to EMU. A second emu_re_i while pending overwrites the address (latest wins).
- EMU: ram_en_o=1, ram_we_o=0, ram_addr_o=emu_addr_q. The next cycle's ram_rdata_i is registered into emu_data_o.
- HOST: ram_en_o=1, ram_we_o=host_we_i, ram_addr_o=host_addr_i, ram_wdata_o=host_wdata_i. host_gnt_o=1 in this cycle.
  - For a read, ram_rdata_i is registered into host_rdata_o, and host_rvalid_o pulses the cycle after that.
  - A write produces no rvalid.
- Accesses execute in issue order. A host write followed by an emulator read of the same address returns the new word.
- All RAM outputs are decoded from registered state; RAM outputs are 0 in IDLE.

## Timing
- Reset (rst_ni=0 at an edge):
  - State goes to IDLE, and emu_pend is cleared.
  - emu_data_o, host_rdata_o, host_gnt_o, host_rvalid_o and all ram_* outputs go to 0.
  - Any in-flight read capture is discarded, with no rvalid.
- Emulator read with emu_re_i in cycle t:
  - emu_pend=1 in t+1.
  - With IDLE in t+1: EMU in t+2, and new emu_data_o visible in t+4.
  - With HOST or EMU in t+1: EMU in t+3, and emu_data_o in t+5.
  - Worst case is 5 cycles. The emulator must not sample emu_data_o earlier than 6 cycles after emu_re_i.
- Host read granted in cycle k: host_rvalid_o and host_rdata_o in k+2.
- Host throughput: one access per 2 cycles when there is no emulator traffic.
- emu_re_i and host_req_i in the same cycle: the emulator is served first, and the host is granted 2 cycles later.

## Configuration
- EEPROM_ARB_WP_EN defined:
  - Adds ports wp_i (in, 1, write-protect) and host_err_o (out, 1).
  - A host write in HOST while wp_i=1 is still granted, but ram_en_o and ram_we_o stay 0.
  - host_err_o pulses in the same cycle as host_gnt_o. host_err_o resets to 0.
- Undefined: neither port exists, and all host writes execute.

## Structure
- Package eeprom_arb_pkg holds:
  - the state enum (IDLE, EMU, HOST);
  - default ADDR_W/DATA_W constants;
  - the worst-case emulator latency constant EMU_RD_LAT=5, shared with the emulator integration.
- Single module. No sub-module is warranted, because the FSM, pending register and capture registers are tightly coupled.

## Test plan
- rst_ni=0 for 3 cycles with host_req_i=1 and emu_re_i=1 -> all outputs 0 and no grant. The first grant is the emulator access, after reset release.
- Host write 0x12<-0xBEEF, then host read 0x12 -> each access gets a single gnt, with no double grant. rvalid comes 2 cycles after the read gnt, with 0xBEEF.
- emu_re_i with addr 0x12 in cycle t while IDLE -> ram_en_o with addr 0x12 in t+2, and emu_data_o=0xBEEF in t+4.
- emu_re_i and host read 0x34 in the same cycle -> EMU access in t+2, host_gnt_o in t+4, host_rvalid_o in t+6.
- Host read granted in t+1, emu_re_i in t -> EMU in t+3, and emu_data_o updated by t+5.
- With EEPROM_ARB_WP_EN, wp_i=1, write 0x12<-0x0000 -> gnt and host_err_o pulse, with ram_we_o kept 0. A following emulator read of 0x12 returns 0xBEEF.
